// File: rtl/sys_axi_pkg.sv
// Shared AXI read-address definitions: burst encodings and AR legality helpers.
package sys_axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   // A WRAP burst must be 2, 4, 8 or 16 beats long.
   function automatic logic ar_wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Beat sizes top out at 128 bytes, so only the low 7 address bits matter.
   function automatic logic ar_aligned(input logic [6:0] addr, input logic [2:0] size);
      logic [6:0] mask;
      mask = 7'((8'd1 << size) - 8'd1);
      return (addr & mask) == 7'd0;
   endfunction

endpackage

// File: rtl/sys_axi_ar_fifo_mem.sv
// Payload store for the AR buffer: DEPTH x W registers, written on push, read asynchronously.
module sys_axi_ar_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   // NOTE: the array has no reset; occupancy lives in the top's count, and stale slots are never presented as valid.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sys_axi_ar_fifo.sv
// AXI4 AR channel buffer (MODE 1 FIFO / MODE 0 pass-through) with sticky burst-legality flag.
// Optional counters enabled by `SYS_AXI_AR_FIFO_PERF_EN.
module sys_axi_ar_fifo
   import sys_axi_pkg::*;
#(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 4,
   parameter int MODE   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ID_W-1:0]            s_arid,
   input  logic [ADDR_W-1:0]          s_araddr,
   input  logic [7:0]                 s_arlen,
   input  logic [2:0]                 s_arsize,
   input  logic [2:0]                 s_arprot,
   input  logic [1:0]                 s_arburst,
   input  logic                       s_arlock,
   input  logic [3:0]                 s_arcache,
   input  logic [3:0]                 s_arqos,
   input  logic [3:0]                 s_arregion,
   input  logic                       s_arvalid,
   output logic                       s_arready,
   output logic [ID_W-1:0]            m_arid,
   output logic [ADDR_W-1:0]          m_araddr,
   output logic [7:0]                 m_arlen,
   output logic [2:0]                 m_arsize,
   output logic [2:0]                 m_arprot,
   output logic [1:0]                 m_arburst,
   output logic                       m_arlock,
   output logic [3:0]                 m_arcache,
   output logic [3:0]                 m_arqos,
   output logic [3:0]                 m_arregion,
   output logic                       m_arvalid,
   input  logic                       m_arready,
   output logic [$clog2(DEPTH+1)-1:0] level,
`ifdef SYS_AXI_AR_FIFO_PERF_EN
   output logic [31:0]                perf_stall,
   output logic [$clog2(DEPTH+1)-1:0] perf_maxlvl,
`endif
   output logic                       err_burst
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int PAY_W = ID_W + ADDR_W + 8 + 3 + 3 + 2 + 1 + 4 + 4 + 4;

   logic [LVL_W-1:0] count;
   logic             push;
   logic             pop;
   logic             burst_bad;

   assign push  = s_arvalid && s_arready;
   assign pop   = m_arvalid && m_arready;
   assign level = count;

   if (MODE == 0) begin : g_pass
      assign {m_arid, m_araddr, m_arlen, m_arsize, m_arprot, m_arburst,
              m_arlock, m_arcache, m_arqos, m_arregion} =
             {s_arid, s_araddr, s_arlen, s_arsize, s_arprot, s_arburst,
              s_arlock, s_arcache, s_arqos, s_arregion};
      assign m_arvalid = s_arvalid;
      assign s_arready = m_arready;
      assign count     = '0;
   end else begin : g_fifo
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [LVL_W-1:0] count_next;
      logic [PAY_W-1:0] wdata;
      logic [PAY_W-1:0] rdata;

      assign wdata = {s_arid, s_araddr, s_arlen, s_arsize, s_arprot, s_arburst,
                      s_arlock, s_arcache, s_arqos, s_arregion};
      assign {m_arid, m_araddr, m_arlen, m_arsize, m_arprot, m_arburst,
              m_arlock, m_arcache, m_arqos, m_arregion} = rdata;
      assign m_arvalid = (count != '0);

      always_comb begin
         // NOTE: default first so every path assigns count_next and no latch is inferred.
         count_next = count;
         case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
         endcase
      end

      // Ready is registered from the next occupancy, so a pop while full only reopens a cycle later.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            s_arready <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            s_arready <= (count_next < LVL_W'(DEPTH));
         end
      end

      sys_axi_ar_fifo_mem #(.DEPTH(DEPTH), .W(PAY_W)) u_mem (
         .clk   (clk),
         .we    (push),
         .waddr (wr_ptr),
         .wdata (wdata),
         .raddr (rd_ptr),
         .rdata (rdata)
      );
   end

   assign burst_bad = (s_arburst == 2'b11) ||
                      ((s_arburst == BURST_WRAP) &&
                       (!ar_wrap_len_ok(s_arlen) || !ar_aligned(s_araddr[6:0], s_arsize)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    err_burst <= 1'b0;
      else if (push && burst_bad) err_burst <= 1'b1;
   end

`ifdef SYS_AXI_AR_FIFO_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall  <= '0;
         perf_maxlvl <= '0;
      end else begin
         if (s_arvalid && !s_arready && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
         if (count > perf_maxlvl) perf_maxlvl <= count;
      end
   end
`endif

endmodule

// File: tb/tb_sys_axi_ar_fifo.sv
// Directed bench for sys_axi_ar_fifo: FIFO instance (MODE 1) and pass-through instance (MODE 0).
module tb_sys_axi_ar_fifo;
   import sys_axi_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  s_arid;
   logic [63:0] s_araddr;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize, s_arprot;
   logic [1:0]  s_arburst;
   logic        s_arlock;
   logic [3:0]  s_arcache, s_arqos, s_arregion;
   logic        s_arvalid, s_arready, m_arready;
   logic [3:0]  m_arid;
   logic [63:0] m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize, m_arprot;
   logic [1:0]  m_arburst;
   logic        m_arlock, m_arvalid, err_burst;
   logic [3:0]  m_arcache, m_arqos, m_arregion;
   logic [2:0]  level;

   logic        s_arvalid0, s_arready0, m_arready0;
   logic [3:0]  m_arid0;
   logic [63:0] m_araddr0;
   logic [7:0]  m_arlen0;
   logic [2:0]  m_arsize0, m_arprot0;
   logic [1:0]  m_arburst0;
   logic        m_arlock0, m_arvalid0, err_burst0;
   logic [3:0]  m_arcache0, m_arqos0, m_arregion0;
   logic [2:0]  level0;
`ifdef SYS_AXI_AR_FIFO_PERF_EN
   logic [31:0] perf_stall, perf_stall0;
   logic [2:0]  perf_maxlvl, perf_maxlvl0;
`endif

   sys_axi_ar_fifo #(.ID_W(4), .ADDR_W(64), .DEPTH(4), .MODE(1)) dut (
      .clk(clk), .rst(rst),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arprot(s_arprot), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
      .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arprot(m_arprot), .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
      .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .level(level),
`ifdef SYS_AXI_AR_FIFO_PERF_EN
      .perf_stall(perf_stall), .perf_maxlvl(perf_maxlvl),
`endif
      .err_burst(err_burst)
   );

   sys_axi_ar_fifo #(.ID_W(4), .ADDR_W(64), .DEPTH(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arprot(s_arprot), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
      .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arvalid(s_arvalid0), .s_arready(s_arready0),
      .m_arid(m_arid0), .m_araddr(m_araddr0), .m_arlen(m_arlen0), .m_arsize(m_arsize0),
      .m_arprot(m_arprot0), .m_arburst(m_arburst0), .m_arlock(m_arlock0), .m_arcache(m_arcache0),
      .m_arqos(m_arqos0), .m_arregion(m_arregion0), .m_arvalid(m_arvalid0), .m_arready(m_arready0),
      .level(level0),
`ifdef SYS_AXI_AR_FIFO_PERF_EN
      .perf_stall(perf_stall0), .perf_maxlvl(perf_maxlvl0),
`endif
      .err_burst(err_burst0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        clr;
      logic        mr;
      logic [1:0]  burst;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [3:0]  id;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[11];
   logic [3:0]  got_ids[$];
   logic [63:0] exp_addr[$];
   logic        p_pop, p_push;
   logic [3:0]  pid;
   logic [63:0] paddr;
   int          bad, pushes, pops;

   initial begin
      vecs[0]  = '{1'b0, 1'b1, BURST_INCR,  8'd7,  3'd3, 64'h1000, 4'd1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, BURST_FIXED, 8'd0,  3'd2, 64'h0003, 4'd2, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, BURST_WRAP,  8'd3,  3'd2, 64'h0010, 4'd3, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, BURST_WRAP,  8'd15, 3'd6, 64'h01C0, 4'd4, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, BURST_WRAP,  8'd1,  3'd3, 64'h0008, 4'd5, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, BURST_WRAP,  8'd5,  3'd2, 64'h0000, 4'd6, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, BURST_INCR,  8'd5,  3'd2, 64'h0004, 4'd7, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, BURST_WRAP,  8'd7,  3'd3, 64'h0004, 4'd8, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 2'b11,       8'd0,  3'd0, 64'h0000, 4'd9, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, BURST_WRAP,  8'd5,  3'd0, 64'h0000, 4'hA, 1'b0};
      vecs[10] = '{1'b0, 1'b1, BURST_WRAP,  8'd15, 3'd7, 64'h0080, 4'hB, 1'b0};

      // Reset held with a request pending
      rst = 1'b1;
      s_arvalid = 1'b1; m_arready = 1'b0; s_arvalid0 = 1'b0; m_arready0 = 1'b0;
      s_arid = 4'd0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arprot = 3'd2;
      s_arburst = BURST_INCR; s_arlock = 1'b0; s_arcache = 4'h3; s_arqos = 4'h5; s_arregion = 4'h9;
      tick(); tick(); tick();
      check("rst_sready", s_arready, 0);
      check("rst_mvalid", m_arvalid, 0);
      check("rst_level", level, 0);
      check("rst_err", err_burst, 0);
      rst = 1'b0;
      s_arvalid = 1'b0;
      check("rel_sready_low", s_arready, 0);
      tick();
      check("rel_sready_high", s_arready, 1);

      // Pass-through and legality vectors on the MODE 0 instance
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].clr) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         s_arid = vecs[i].id; s_araddr = vecs[i].addr; s_arlen = vecs[i].len;
         s_arsize = vecs[i].size; s_arburst = vecs[i].burst;
         m_arready0 = vecs[i].mr; s_arvalid0 = 1'b1;
         #1;
         check($sformatf("v%0d_sready", i), s_arready0, vecs[i].mr);
         check($sformatf("v%0d_mvalid", i), m_arvalid0, 1);
         check($sformatf("v%0d_id", i), m_arid0, vecs[i].id);
         check($sformatf("v%0d_addr", i), m_araddr0, vecs[i].addr);
         check($sformatf("v%0d_len", i), m_arlen0, vecs[i].len);
         check($sformatf("v%0d_burst", i), m_arburst0, vecs[i].burst);
         check($sformatf("v%0d_qos", i), m_arqos0, 4'h5);
         check($sformatf("v%0d_level0", i), level0, 0);
         tick();
         check($sformatf("v%0d_err", i), err_burst0, vecs[i].exp_err);
         s_arvalid0 = 1'b0;
      end
      tick();
      s_arburst = BURST_INCR; s_arlen = 8'd0; s_arsize = 3'd2; s_araddr = 64'h100;

      // Fill: IDs 1..4 accepted, ID 5 stalls while full
      m_arready = 1'b0;
      s_arvalid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         s_arid = 4'(k);
         tick();
      end
      s_arid = 4'd5;
      for (int k = 0; k < 7; k++) tick();
      check("fill_level", level, 4);
      check("fill_sready", s_arready, 0);
      check("fill_mvalid", m_arvalid, 1);
      check("fill_head_stable", m_arid, 1);
`ifdef SYS_AXI_AR_FIFO_PERF_EN
      check("perf_stall", perf_stall, 7);
      check("perf_maxlvl", perf_maxlvl, 4);
      check("perf_maxlvl_mode0", perf_maxlvl0, 0);
`endif
      m_arready = 1'b1;
      got_ids.delete();
      for (int c = 0; c < 20 && got_ids.size() < 5; c++) begin
         p_pop = m_arvalid && m_arready;
         p_push = s_arvalid && s_arready;
         pid = m_arid;
         tick();
         if (p_pop) got_ids.push_back(pid);
         if (p_push) s_arvalid = 1'b0;
      end
      check("fill_count", 64'(got_ids.size()), 5);
      for (int i = 0; i < 5; i++)
         check($sformatf("fill_order%0d", i), (i < got_ids.size()) ? 64'(got_ids[i]) : 64'hDEAD, 64'(i + 1));
      check("fill_empty", level, 0);

      // Streaming: one accept per cycle, occupancy pinned at 1
      s_arvalid = 1'b1; m_arready = 1'b1; s_araddr = 64'h2000;
      bad = 0; pushes = 0; pops = 0;
      exp_addr.delete();
      for (int c = 0; c < 20; c++) begin
         p_pop = m_arvalid && m_arready;
         p_push = s_arvalid && s_arready;
         paddr = m_araddr;
         tick();
         if (p_pop) begin
            pops++;
            if (exp_addr.size() == 0 || exp_addr[0] !== paddr) bad++;
            if (exp_addr.size() != 0) void'(exp_addr.pop_front());
         end
         if (p_push) begin
            pushes++;
            exp_addr.push_back(s_araddr);
            s_araddr = s_araddr + 64'h40;
         end
         check($sformatf("stream_level%0d", c), level, 1);
      end
      s_arvalid = 1'b0;
      p_pop = m_arvalid && m_arready;
      paddr = m_araddr;
      tick();
      if (p_pop) begin
         pops++;
         if (exp_addr.size() == 0 || exp_addr[0] !== paddr) bad++;
      end
      check("stream_pushes", 64'(pushes), 20);
      check("stream_pops", 64'(pops), 20);
      check("stream_order_errs", 64'(bad), 0);
      check("stream_empty", level, 0);

      // Full with a simultaneous pop: no push that cycle
      m_arready = 1'b0; s_arvalid = 1'b1;
      for (int k = 10; k <= 13; k++) begin
         s_arid = 4'(k);
         tick();
      end
      s_arid = 4'd14;
      check("fp_level4", level, 4);
      check("fp_sready0", s_arready, 0);
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      check("fp_level3", level, 3);
      check("fp_sready1", s_arready, 1);
      check("fp_head", m_arid, 11);
      tick();
      s_arvalid = 1'b0;
      check("fp_level4_again", level, 4);
      check("fp_sready0_again", s_arready, 0);
      m_arready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("fp_drained", level, 0);

      // Legality on the FIFO: illegal WRAP still forwarded, flag sticks
      m_arready = 1'b0;
      s_arid = 4'd7; s_arburst = BURST_WRAP; s_arlen = 8'd5; s_arsize = 3'd2; s_araddr = 64'h0;
      s_arvalid = 1'b1;
      tick();
      s_arvalid = 1'b0;
      check("leg_err", err_burst, 1);
      check("leg_mvalid", m_arvalid, 1);
      check("leg_len", m_arlen, 5);
      check("leg_burst", m_arburst, BURST_WRAP);
      s_arid = 4'd8; s_arburst = BURST_INCR; s_arlen = 8'd3;
      s_arvalid = 1'b1;
      tick();
      s_arvalid = 1'b0;
      check("leg_err_sticky", err_burst, 1);
      check("leg_level", level, 2);
      m_arready = 1'b1;
      tick();
      check("leg_second", m_arid, 8);
      tick();
      check("leg_drained", level, 0);

      // Asynchronous reset mid-transfer drops stored entries
      m_arready = 1'b0; s_arvalid = 1'b1;
      tick(); tick();
      s_arvalid = 1'b0;
      check("mid_level2", level, 2);
      #3 rst = 1'b1;
      #1;
      check("mid_async_mvalid", m_arvalid, 0);
      check("mid_async_level", level, 0);
      check("mid_async_sready", s_arready, 0);
      check("mid_async_err", err_burst, 0);
      tick();
      rst = 1'b0;
      check("mid_rel_mvalid", m_arvalid, 0);
      tick();
      check("mid_after_mvalid", m_arvalid, 0);
      check("mid_after_sready", s_arready, 1);
      check("mid_after_level", level, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
